// File: rtl/fm_tx_sequencer.sv
// FM transmit sequencer: keyed soft-ramp gain in front of the modulator,
// with an underrun watchdog that keeps the output sample cadence going.
module fm_tx_sequencer #(
  parameter int WIDTH     = 16,
  parameter int FCLK      = 48000000,
  parameter int FS_IN     = 48000,
  parameter int RAMP_LOG2 = 8,
  parameter int SLACK     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             clear_underrun,
  input  logic [WIDTH-1:0] data_in,
  input  logic             stb_in,
  output logic [WIDTH-1:0] data_out,
  output logic             stb_out,
  output logic             tx_on,
  output logic [1:0]       state,
  output logic             underrun,
  output logic [31:0]      sample_count
);

  localparam int R  = RAMP_LOG2;
  localparam int PW = WIDTH + R + 2;
  localparam logic [R:0] G_MAX = {1'b1, {R{1'b0}}};
  localparam logic [R:0] ONE   = {{R{1'b0}}, 1'b1};
  localparam logic [31:0] WD_MAX = 32'(FCLK / FS_IN + SLACK - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RAMP_UP   = 2'd1,
    ACTIVE    = 2'd2,
    RAMP_DOWN = 2'd3
  } state_t;

  state_t st, st_n;
  logic [R:0] gain, gain_n;
  logic [31:0] wd, wd_n;
  logic expire, emit, clr_run;
  logic signed [WIDTH-1:0] sample, data_nxt;
  logic signed [PW-1:0] sample_x, gain_x, prod;

  assign expire = (st != IDLE) && !stb_in && (wd == WD_MAX);
  assign emit   = (st != IDLE) && (stb_in || expire);
  assign sample = stb_in ? $signed(data_in) : '0;

  // Gain is zero-extended so it stays non-negative in the signed product
  assign sample_x = PW'(sample);
  assign gain_x   = $signed(PW'(gain));
  assign prod     = sample_x * gain_x;
  assign data_nxt = WIDTH'(prod >>> R);

  assign tx_on = (st != IDLE);
  assign state = st;

  always_comb begin
    st_n    = st;
    gain_n  = gain;
    wd_n    = wd;
    clr_run = 1'b0;
    if (st != IDLE) wd_n = emit ? '0 : wd + 32'd1;
    unique case (st)
      IDLE: begin
        wd_n = '0;
        if (start && !stop) begin
          st_n    = RAMP_UP;
          gain_n  = '0;
          clr_run = 1'b1;
        end
      end
      RAMP_UP: begin
        // Saturate so a re-key from a full-gain ramp-down cannot overshoot
        if (emit) begin
          if (gain >= G_MAX - ONE) begin
            gain_n = G_MAX;
            st_n   = ACTIVE;
          end else begin
            gain_n = gain + ONE;
          end
        end
        if (stop) st_n = RAMP_DOWN;
      end
      ACTIVE: begin
        gain_n = G_MAX;
        if (stop) st_n = RAMP_DOWN;
      end
      RAMP_DOWN: begin
        if (emit) begin
          if (gain == '0) st_n = IDLE;
          else gain_n = gain - ONE;
        end
        if (start && !stop) st_n = RAMP_UP;
      end
      default: st_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st           <= IDLE;
      gain         <= '0;
      wd           <= '0;
      data_out     <= '0;
      stb_out      <= 1'b0;
      underrun     <= 1'b0;
      sample_count <= '0;
    end else begin
      st      <= st_n;
      gain    <= gain_n;
      wd      <= wd_n;
      stb_out <= emit;
      if (emit) data_out <= data_nxt;
      if (expire) underrun <= 1'b1;
      else if (clr_run || clear_underrun) underrun <= 1'b0;
      if (clr_run) sample_count <= '0;
      else if (emit) sample_count <= sample_count + 32'd1;
    end
  end

endmodule

// File: doc/fm_tx_sequencer.md
Name: fm_tx_sequencer

Overview:
- Transmit-side controller in front of the FM modulator audio input.
- Sequences keying on and off with a soft amplitude ramp, so switching produces no clicks or spectral splatter.
- Drives the modulator's run-enable.
- Guarantees an uninterrupted FS_IN sample cadence: a watchdog inserts zero samples if the upstream audio source underruns.

Parameters:
- WIDTH, 16, signed audio sample width (two's complement).
- FCLK, 48000000, system clock frequency in Hz.
- FS_IN, 48000, nominal audio sample rate in Hz. Nominal period P = FCLK/FS_IN clocks (1000 by default).
- RAMP_LOG2, 8, ramp length exponent R. Full-scale gain G_MAX = 2^R. A ramp lasts G_MAX samples.
- SLACK, 8, extra clocks beyond P tolerated before an underrun is declared.

Ports:
- clk  in  1  system clock, all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle key-on request.
- stop  in  1  single-cycle key-off request.
- clear_underrun  in  1  clears the sticky underrun flag.
- data_in  in  WIDTH  signed audio sample.
- stb_in  in  1  data_in valid for one cycle.
- data_out  out  WIDTH  gain-scaled sample to the modulator.
- stb_out  out  1  data_out valid for one cycle.
- tx_on  out  1  modulator run-enable.
- state  out  2  current state: 0 IDLE, 1 RAMP_UP, 2 ACTIVE, 3 RAMP_DOWN.
- underrun  out  1  sticky flag: at least one sample was inserted.
- sample_count  out  32  number of stb_out pulses since the last key-on.

Behaviour:
- Reset: state IDLE, gain 0, watchdog 0. data_out, stb_out, tx_on, underrun and sample_count are all 0. rst overrides every other input in the same cycle.
- IDLE:
  - stb_in is ignored and stb_out stays 0.
  - start -> RAMP_UP. In the same transition: gain=0, sample_count=0, underrun=0, watchdog=0.
- RAMP_UP:
  - Each emitted sample (accepted or inserted) uses the current gain, then gain += 1.
  - When the post-increment gain equals G_MAX -> ACTIVE.
  - stop -> RAMP_DOWN, keeping the current gain.
- ACTIVE:
  - gain is held at G_MAX.
  - stop -> RAMP_DOWN.
  - start is ignored.
- RAMP_DOWN:
  - Each emitted sample uses the current gain, then gain -= 1 (saturating at 0).
  - After the sample emitted with gain 0 -> IDLE.
  - start -> RAMP_UP, keeping the current gain.
- start and stop in the same cycle: stop wins in RAMP_UP and ACTIVE. In IDLE and RAMP_DOWN both are ignored (no state change).
- A command arriving in the same cycle as a sample: the sample is processed with the pre-command state and gain. The state change takes effect the next cycle.
- tx_on: 1 in every state except IDLE. It goes high the cycle the state register enters RAMP_UP and low the cycle it enters IDLE.
- Datapath:
  - data_out = (data_in * gain) >>> R.
  - Full-precision signed product of WIDTH+R+1 bits, arithmetic shift (floor rounding), no saturation needed because gain <= G_MAX.
  - Registered: stb_out and data_out appear exactly 1 cycle after the stb_in or insertion event.
  - data_out holds its last value while stb_out=0.
- Watchdog (non-IDLE states only):
  - Counts clocks since the last emitted sample and is cleared on every stb_in.
  - On reaching P+SLACK-1 with no stb_in that cycle: insert a sample with value 0 (data_out=0 one cycle later), set underrun=1, clear the counter.
  - stb_in in the expiry cycle wins: no insertion.
- underrun: sticky. Cleared by clear_underrun or by start from IDLE. Set has priority over clear in the same cycle.
- sample_count: increments on every stb_out and wraps at 2^32.
- Mid-operation rst: immediate return to IDLE with tx_on=0. Any pending output sample is dropped.

Test Plan (R=2, so G_MAX=4; P=1000, SLACK=8):
- Reset, then stb_in pulses in IDLE -> stb_out never asserts; tx_on=0; state=0.
- start, then 6 samples of 1000 -> tx_on high the next cycle; data_out = 0, 250, 500, 750, 1000, 1000; state 1→2 after the 4th sample; sample_count=6.
- From ACTIVE: stop, then 5 samples of -1000 -> data_out = -1000, -750, -500, -250, 0; state 3, then 0 after the 5th; tx_on low.
- In ACTIVE, withhold stb_in for 1007 clocks -> a stb_out with data 0 at clock 1008 after the last sample; underrun=1 until clear_underrun; with stb_in exactly at expiry -> no insertion.
- start and stop in the same cycle in ACTIVE -> RAMP_DOWN. In RAMP_UP at gain 2, stop -> the next sample uses gain 2 (16000 -> 8000), then 1.
- Assert rst during RAMP_DOWN with a sample in flight -> all outputs 0 next cycle; no stb_out; state 0.
